// File: rtl/axi3_master.sv
// Single-outstanding AXI3 master bridging the fabric req/ack word bus
// onto a single-beat HP port (one AW/W/B or AR/R exchange per request).
module axi3_master #(
    parameter int IDW = 6,
    parameter logic [IDW-1:0] ID = '0
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           dma_req,
    input  logic           dma_wr,
    input  logic [31:0]    dma_addr,
    input  logic [31:0]    dma_wdata,
    input  logic [3:0]     dma_wstrb,
    output logic           dma_ack,
    output logic [31:0]    dma_rdata,
    output logic           dma_err,
    output logic           hp0_awvalid,
    input  logic           hp0_awready,
    output logic [31:0]    hp0_awaddr,
    output logic           hp0_wvalid,
    input  logic           hp0_wready,
    output logic [31:0]    hp0_wdata,
    output logic [3:0]     hp0_wstrb,
    output logic           hp0_wlast,
    input  logic           hp0_bvalid,
    output logic           hp0_bready,
    input  logic [1:0]     hp0_bresp,
    input  logic [IDW-1:0] hp0_bid,
    output logic           hp0_arvalid,
    input  logic           hp0_arready,
    output logic [31:0]    hp0_araddr,
    input  logic           hp0_rvalid,
    output logic           hp0_rready,
    input  logic [31:0]    hp0_rdata,
    input  logic [1:0]     hp0_rresp,
    input  logic           hp0_rlast,
    input  logic [IDW-1:0] hp0_rid,
    output logic [IDW-1:0] hp0_awid,
    output logic [IDW-1:0] hp0_wid,
    output logic [IDW-1:0] hp0_arid,
    output logic [3:0]     hp0_awlen,
    output logic [3:0]     hp0_arlen,
    output logic [2:0]     hp0_awsize,
    output logic [2:0]     hp0_arsize,
    output logic [1:0]     hp0_awburst,
    output logic [1:0]     hp0_arburst,
    output logic [1:0]     hp0_awlock,
    output logic [1:0]     hp0_arlock,
    output logic [3:0]     hp0_awcache,
    output logic [3:0]     hp0_arcache,
    output logic [2:0]     hp0_awprot,
    output logic [2:0]     hp0_arprot,
    output logic [3:0]     hp0_awqos,
    output logic [3:0]     hp0_arqos
);

    typedef enum logic [2:0] {
        IDLE, WREQ, WRESP, RREQ, RRESP, ACK
    } state_t;

    state_t      state_q, state_d;
    logic        aw_done, w_done;
    logic        aw_hs, w_hs;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = ^dma_addr[1:0];

    assign hp0_awaddr  = addr_q;
    assign hp0_araddr  = addr_q;
    assign hp0_wdata   = wdata_q;
    assign hp0_wstrb   = wstrb_q;
    assign hp0_wlast   = 1'b1;
    assign hp0_awid    = ID;
    assign hp0_wid     = ID;
    assign hp0_arid    = ID;
    assign hp0_awlen   = 4'd0;
    assign hp0_arlen   = 4'd0;
    assign hp0_awsize  = 3'd2;
    assign hp0_arsize  = 3'd2;
    assign hp0_awburst = 2'd1;
    assign hp0_arburst = 2'd1;
    assign hp0_awlock  = 2'd0;
    assign hp0_arlock  = 2'd0;
    assign hp0_awcache = 4'b0011;
    assign hp0_arcache = 4'b0011;
    assign hp0_awprot  = 3'd0;
    assign hp0_arprot  = 3'd0;
    assign hp0_awqos   = 4'd0;
    assign hp0_arqos   = 4'd0;

    assign aw_hs = hp0_awvalid & hp0_awready;
    assign w_hs  = hp0_wvalid & hp0_wready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            dma_rdata <= '0;
            dma_err   <= 1'b0;
        end else begin
            state_q <= state_d;
            // AW and W complete independently; each flag remembers its own beat
            aw_done <= (state_q == WREQ) && (aw_done || aw_hs);
            w_done  <= (state_q == WREQ) && (w_done || w_hs);
            if (state_q == IDLE && dma_req) begin
                addr_q  <= {dma_addr[31:2], 2'b00};
                wdata_q <= dma_wdata;
                wstrb_q <= dma_wstrb;
            end
            if (state_q == WRESP && hp0_bvalid)
                dma_err <= hp0_bresp[1] | (hp0_bid != ID);
            if (state_q == RRESP && hp0_rvalid) begin
                dma_rdata <= hp0_rdata;
                dma_err   <= hp0_rresp[1] | (hp0_rid != ID) | ~hp0_rlast;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        hp0_awvalid = 1'b0;
        hp0_wvalid  = 1'b0;
        hp0_bready  = 1'b0;
        hp0_arvalid = 1'b0;
        hp0_rready  = 1'b0;
        dma_ack     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (dma_req)
                    state_d = dma_wr ? WREQ : RREQ;
            end
            WREQ: begin
                hp0_awvalid = ~aw_done;
                hp0_wvalid  = ~w_done;
                if ((aw_done || aw_hs) && (w_done || w_hs))
                    state_d = WRESP;
            end
            WRESP: begin
                hp0_bready = 1'b1;
                if (hp0_bvalid)
                    state_d = ACK;
            end
            RREQ: begin
                hp0_arvalid = 1'b1;
                if (hp0_arready)
                    state_d = RRESP;
            end
            RRESP: begin
                hp0_rready = 1'b1;
                if (hp0_rvalid)
                    state_d = ACK;
            end
            ACK: begin
                dma_ack = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi3_master.sv
// Bench for axi3_master: DDR slave model with tunable wait states,
// reference memory model and an ack-driven scoreboard.
module tb_axi3_master;

    localparam int IDW = 6;
    localparam logic [IDW-1:0] ID = 6'd0;

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic           dma_req = 1'b0, dma_wr = 1'b0;
    logic [31:0]    dma_addr = '0, dma_wdata = '0;
    logic [3:0]     dma_wstrb = '0;
    logic           dma_ack, dma_err;
    logic [31:0]    dma_rdata;
    logic           hp0_awvalid, hp0_awready = 1'b0;
    logic [31:0]    hp0_awaddr;
    logic           hp0_wvalid, hp0_wready = 1'b0;
    logic [31:0]    hp0_wdata;
    logic [3:0]     hp0_wstrb;
    logic           hp0_wlast;
    logic           hp0_bvalid = 1'b0, hp0_bready;
    logic [1:0]     hp0_bresp = '0;
    logic [IDW-1:0] hp0_bid = '0;
    logic           hp0_arvalid, hp0_arready = 1'b0;
    logic [31:0]    hp0_araddr;
    logic           hp0_rvalid = 1'b0, hp0_rready;
    logic [31:0]    hp0_rdata = '0;
    logic [1:0]     hp0_rresp = '0;
    logic           hp0_rlast = 1'b0;
    logic [IDW-1:0] hp0_rid = '0;
    logic [IDW-1:0] hp0_awid, hp0_wid, hp0_arid;
    logic [3:0]     hp0_awlen, hp0_arlen;
    logic [2:0]     hp0_awsize, hp0_arsize;
    logic [1:0]     hp0_awburst, hp0_arburst;
    logic [1:0]     hp0_awlock, hp0_arlock;
    logic [3:0]     hp0_awcache, hp0_arcache;
    logic [2:0]     hp0_awprot, hp0_arprot;
    logic [3:0]     hp0_awqos, hp0_arqos;

    axi3_master #(.IDW(IDW), .ID(ID)) dut (
        .clk(clk), .resetn(resetn),
        .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_wstrb(dma_wstrb),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata), .dma_err(dma_err),
        .hp0_awvalid(hp0_awvalid), .hp0_awready(hp0_awready),
        .hp0_awaddr(hp0_awaddr),
        .hp0_wvalid(hp0_wvalid), .hp0_wready(hp0_wready),
        .hp0_wdata(hp0_wdata), .hp0_wstrb(hp0_wstrb), .hp0_wlast(hp0_wlast),
        .hp0_bvalid(hp0_bvalid), .hp0_bready(hp0_bready),
        .hp0_bresp(hp0_bresp), .hp0_bid(hp0_bid),
        .hp0_arvalid(hp0_arvalid), .hp0_arready(hp0_arready),
        .hp0_araddr(hp0_araddr),
        .hp0_rvalid(hp0_rvalid), .hp0_rready(hp0_rready),
        .hp0_rdata(hp0_rdata), .hp0_rresp(hp0_rresp),
        .hp0_rlast(hp0_rlast), .hp0_rid(hp0_rid),
        .hp0_awid(hp0_awid), .hp0_wid(hp0_wid), .hp0_arid(hp0_arid),
        .hp0_awlen(hp0_awlen), .hp0_arlen(hp0_arlen),
        .hp0_awsize(hp0_awsize), .hp0_arsize(hp0_arsize),
        .hp0_awburst(hp0_awburst), .hp0_arburst(hp0_arburst),
        .hp0_awlock(hp0_awlock), .hp0_arlock(hp0_arlock),
        .hp0_awcache(hp0_awcache), .hp0_arcache(hp0_arcache),
        .hp0_awprot(hp0_awprot), .hp0_arprot(hp0_arprot),
        .hp0_awqos(hp0_awqos), .hp0_arqos(hp0_arqos)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
        end
    endtask

    // slave knobs: wait states per channel and error injection
    int k_aw = 0, k_w = 0, k_b = 0, k_ar = 0, k_r = 0;
    bit k_eresp = 0, k_eid = 0, k_elast = 0;
    logic [31:0] k_addr = '0;

    logic [31:0] slave_mem [logic [29:0]];
    logic [31:0] ref_mem [logic [29:0]];
    logic [31:0] last_rdata = '0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    // ---------------- slave model ----------------
    bit aw_done = 0, w_done = 0, ar_done = 0, b_pend = 0, r_pend = 0;
    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
    logic [29:0] aw_word, ar_word;
    logic [31:0] w_data;
    logic [3:0]  w_strb;

    always @(negedge clk) begin
        if (!resetn) begin
            aw_done = 0; w_done = 0; ar_done = 0; b_pend = 0; r_pend = 0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
            hp0_awready = 0; hp0_wready = 0; hp0_arready = 0;
            hp0_bvalid = 0; hp0_rvalid = 0;
        end else begin
            if (aw_done) chk("awvalid_after_hs", 32'(hp0_awvalid), 32'd0);
            if (w_done) chk("wvalid_after_hs", 32'(hp0_wvalid), 32'd0);
            if (hp0_bready)
                chk("bready_before_aw_w", 32'(aw_done && w_done), 32'd1);
            if (!b_pend && aw_done && w_done && !hp0_bvalid) begin
                logic [31:0] m;
                m = slave_mem.exists(aw_word) ? slave_mem[aw_word] : 32'd0;
                for (int i = 0; i < 4; i++)
                    if (w_strb[i]) m[i*8 +: 8] = w_data[i*8 +: 8];
                slave_mem[aw_word] = m;
                b_pend = 1; b_cnt = 0;
                hp0_bresp = k_eresp ? 2'b10 : {1'b0, 1'($urandom % 2)};
                hp0_bid = k_eid ? (ID ^ 6'd1) : ID;
            end
            if (b_pend) begin
                if (b_cnt >= k_b) begin
                    hp0_bvalid = 1;
                    if (hp0_bready) begin
                        b_pend = 0; aw_done = 0; w_done = 0;
                    end
                end else begin
                    hp0_bvalid = 0; b_cnt++;
                end
            end else hp0_bvalid = 0;
            if (ar_done) begin
                ar_done = 0; r_pend = 1; r_cnt = 0;
                hp0_rdata = slave_mem.exists(ar_word) ? slave_mem[ar_word] : 32'd0;
                hp0_rresp = k_eresp ? 2'b10 : {1'b0, 1'($urandom % 2)};
                hp0_rid = k_eid ? (ID ^ 6'd1) : ID;
                hp0_rlast = !k_elast;
            end
            if (r_pend) begin
                if (r_cnt >= k_r) begin
                    hp0_rvalid = 1;
                    if (hp0_rready) r_pend = 0;
                end else begin
                    hp0_rvalid = 0; r_cnt++;
                end
            end else hp0_rvalid = 0;
            if (hp0_awvalid && !aw_done) begin
                if (aw_cnt >= k_aw) begin
                    hp0_awready = 1; aw_done = 1; aw_word = hp0_awaddr[31:2];
                    chk("awaddr", hp0_awaddr, k_addr);
                    chk("aw_len_size_burst",
                        {hp0_awlen, 1'b0, hp0_awsize, 2'b0, hp0_awburst},
                        {4'd0, 1'b0, 3'd2, 2'b0, 2'd1});
                    chk("awid_cache", {hp0_awid, hp0_awcache}, {ID, 4'b0011});
                end else begin
                    hp0_awready = 0; aw_cnt++;
                end
            end else begin
                hp0_awready = 0; aw_cnt = 0;
            end
            if (hp0_wvalid && !w_done) begin
                if (w_cnt >= k_w) begin
                    hp0_wready = 1; w_done = 1;
                    w_data = hp0_wdata; w_strb = hp0_wstrb;
                    chk("wlast", 32'(hp0_wlast), 32'd1);
                end else begin
                    hp0_wready = 0; w_cnt++;
                end
            end else begin
                hp0_wready = 0; w_cnt = 0;
            end
            if (hp0_arvalid && !ar_done && !r_pend) begin
                if (ar_cnt >= k_ar) begin
                    hp0_arready = 1; ar_done = 1; ar_word = hp0_araddr[31:2];
                    chk("araddr", hp0_araddr, k_addr);
                    chk("ar_len_size", {hp0_arlen, 1'b0, hp0_arsize},
                        {4'd0, 1'b0, 3'd2});
                end else begin
                    hp0_arready = 0; ar_cnt++;
                end
            end else begin
                hp0_arready = 0; ar_cnt = 0;
            end
        end
    end

    // ---------------- monitor ----------------
    logic prev_ack = 0;
    always @(negedge clk) begin
        if (resetn && dma_ack) begin
            chk("ack_single_pulse", 32'(prev_ack), 32'd0);
            if (sb.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_ack actual=1 required=0");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("dma_rdata", dma_rdata, e.rdata);
                chk("dma_err", 32'(dma_err), 32'(e.err));
            end
        end
        prev_ack = resetn & dma_ack;
    end

    // ---------------- stimulus ----------------
    task automatic knobs(input int aw, w, b, ar, r,
                         input bit er, ei, el);
        k_aw = aw; k_w = w; k_b = b; k_ar = ar; k_r = r;
        k_eresp = er; k_eid = ei; k_elast = el;
    endtask

    task automatic run(input bit wr, input logic [31:0] a, d,
                       input logic [3:0] s, input int exp_lat);
        exp_t e;
        logic [29:0] wd;
        logic [31:0] m;
        int t0;
        bit got;
        wd = a[31:2];
        m = ref_mem.exists(wd) ? ref_mem[wd] : 32'd0;
        if (wr) begin
            for (int i = 0; i < 4; i++)
                if (s[i]) m[i*8 +: 8] = d[i*8 +: 8];
            ref_mem[wd] = m;
            e.err = k_eresp | k_eid;
        end else begin
            last_rdata = m;
            e.err = k_eresp | k_eid | k_elast;
        end
        e.rdata = last_rdata;
        @(negedge clk);
        k_addr = {a[31:2], 2'b00};
        sb.push_back(e);
        dma_req = 1; dma_wr = wr; dma_addr = a; dma_wdata = d; dma_wstrb = s;
        t0 = cyc;
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (dma_ack) got = 1;
        end
        dma_req = 0;
        if (!got) chk("ack_timeout", 32'd0, 32'd1);
        else if (exp_lat >= 0) chk("latency", 32'(cyc - t0), 32'(exp_lat));
    endtask

    initial begin
        slave_mem[30'(32'h20000000 >> 2)] = 32'h12345678;
        ref_mem[30'(32'h20000000 >> 2)] = 32'h12345678;
        #1;
        chk("rst_valids",
            {hp0_awvalid, hp0_wvalid, hp0_arvalid, hp0_bready, hp0_rready, dma_ack},
            6'd0);
        chk("rst_rdata", dma_rdata, 32'd0);
        chk("rst_err", 32'(dma_err), 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1;

        knobs(0, 0, 0, 0, 0, 0, 0, 0);
        run(1, 32'h10000007, 32'hCAFEF00D, 4'hF, 3);
        knobs(0, 0, 0, 0, 5, 0, 0, 0);
        run(0, 32'h20000000, 32'h0, 4'h0, 8);

        knobs(3, 0, 0, 0, 0, 0, 0, 0);
        run(1, 32'h20000004, 32'h11112222, 4'hF, 6);
        knobs(0, 3, 1, 0, 0, 0, 0, 0);
        run(1, 32'h20000008, 32'hA5A5A5A5, 4'h5, 7);
        knobs(1, 1, 0, 0, 0, 0, 0, 0);
        run(1, 32'h2000000C, 32'h0BADBEEF, 4'hC, 4);

        knobs(0, 0, 0, 0, 0, 1, 0, 0);
        run(1, 32'h20000010, 32'h01020304, 4'hF, 3);
        knobs(0, 0, 0, 0, 0, 0, 1, 0);
        run(0, 32'h20000004, 32'h0, 4'h0, 3);
        knobs(0, 0, 0, 0, 0, 0, 0, 1);
        run(0, 32'h20000008, 32'h0, 4'h0, 3);

        // abandon a write mid-flight with reset
        knobs(20, 20, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        dma_req = 1; dma_wr = 1; dma_addr = 32'h30000000;
        dma_wdata = 32'hDEADDEAD; dma_wstrb = 4'hF;
        repeat (2) @(negedge clk);
        chk("wreq_awvalid", 32'(hp0_awvalid), 32'd1);
        #2 resetn = 0;
        dma_req = 0;
        #1;
        chk("async_rst_valids",
            {hp0_awvalid, hp0_wvalid, hp0_arvalid, hp0_bready, hp0_rready, dma_ack},
            6'd0);
        chk("async_rst_rdata", dma_rdata, 32'd0);
        last_rdata = '0;
        repeat (2) @(negedge clk);
        #1 resetn = 1;
        knobs(0, 0, 0, 2, 1, 0, 0, 0);
        run(0, 32'h10000004, 32'h0, 4'h0, 6);

        knobs(0, 0, 0, 0, 0, 0, 0, 0);
        run(1, 32'h20000000, 32'h9ABC0000, 4'h3, 3);
        run(0, 32'h20000003, 32'h0, 4'h0, 3);

        for (int n = 0; n < 40; n++) begin
            bit wr;
            bit [2:0] e;
            wr = 1'($urandom % 2);
            e = 3'($urandom % 8);
            knobs(int'($urandom % 4), int'($urandom % 4), int'($urandom % 3),
                  int'($urandom % 4), int'($urandom % 3),
                  e == 3'd1, e == 3'd2, e == 3'd3);
            run(wr, 32'h40000000 | ($urandom % 32), $urandom,
                4'($urandom % 16), -1);
            repeat ($urandom % 3) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
